// File: rtl/bar_motion_controller_pkg.sv
// Shared definitions for the bouncing-bar motion controller: state encoding,
// arithmetic widths and the speed-code-to-step table.
package bar_motion_controller_pkg;

  localparam int POS_W   = 9;
  localparam int ARITH_W = 10;
  localparam int CNT_W   = 16;

  typedef enum logic [2:0] {
    ST_WAIT_PHASE   = 3'd0,
    ST_MOVE_DOWN    = 3'd1,
    ST_PAUSE_BOTTOM = 3'd2,
    ST_MOVE_UP      = 3'd3,
    ST_PAUSE_TOP    = 3'd4
  } bmc_state_e;

  // Lines moved per frame tick; each code doubles the previous step.
  function automatic logic signed [ARITH_W-1:0] speed_to_step(input logic [1:0] code);
    logic signed [ARITH_W-1:0] step;
    case (code)
      2'd0:    step = 10'sd1;
      2'd1:    step = 10'sd2;
      2'd2:    step = 10'sd4;
      2'd3:    step = 10'sd8;
      default: step = 10'sd1;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/frame_tick_edge.sv
// Rising-edge detector for the frame strobe. A level that is already high
// when reset releases must first be seen low before any edge is reported.
module frame_tick_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic pulse_o
);

  logic prev_q;
  logic prev_d;
  logic armed_q;
  logic armed_d;

  // History and arming next-state
  always_comb begin
    prev_d  = level_i;
    armed_d = armed_q | ~level_i;
  end

  // History registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

  assign pulse_o = level_i & ~prev_q & armed_q;

endmodule

// File: rtl/bar_motion_controller.sv
// Moves a split-line position between +/-AMPLITUDE, one step per frame tick,
// with a startup phase delay and a pause at each limit.
module bar_motion_controller
  import bar_motion_controller_pkg::*;
#(
  parameter int PHASE_DELAY_FRAMES = 0,
  parameter int AMPLITUDE          = 120,
  parameter int PAUSE_FRAMES       = 8
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic                    i_NewFrameTick,
  input  logic [1:0]              i_Speed,
  input  logic                    i_Freeze,
  output logic signed [POS_W-1:0] o_Position,
  output logic                    o_MovingDown,
  output logic                    o_AtLimit,
  output logic                    o_Updated
);

  localparam logic signed [ARITH_W-1:0] AMP_POS    = ARITH_W'(AMPLITUDE);
  localparam logic signed [ARITH_W-1:0] AMP_NEG    = -AMP_POS;
  localparam logic        [CNT_W-1:0]   PHASE_INIT = CNT_W'(PHASE_DELAY_FRAMES);
  localparam logic        [CNT_W-1:0]   PAUSE_INIT = CNT_W'(PAUSE_FRAMES);

  logic                      edge_s;
  logic                      tick_q;
  logic                      tick_d;
  logic [1:0]                speed_q;
  logic [1:0]                speed_d;
  logic                      tick_act_s;

  bmc_state_e                state_q;
  bmc_state_e                state_d;
  logic signed [POS_W-1:0]   pos_q;
  logic signed [POS_W-1:0]   pos_d;
  logic [CNT_W-1:0]          phase_cnt_q;
  logic [CNT_W-1:0]          phase_cnt_d;
  logic [CNT_W-1:0]          pause_cnt_q;
  logic [CNT_W-1:0]          pause_cnt_d;
  logic                      moving_down_q;
  logic                      moving_down_d;
  logic                      at_limit_q;
  logic                      at_limit_d;
  logic                      updated_q;
  logic                      updated_d;

  logic signed [ARITH_W-1:0] pos_ext_s;
  logic signed [ARITH_W-1:0] step_s;
  logic signed [ARITH_W-1:0] sum_down_s;
  logic signed [ARITH_W-1:0] sum_up_s;

  frame_tick_edge u_tick_edge (
    .clk_i   (i_Clk),
    .rst_i   (i_Reset),
    .level_i (i_NewFrameTick),
    .pulse_o (edge_s)
  );

  // Tick pipeline stage: edge and speed captured together so the step always
  // belongs to the tick that uses it. A frozen edge is dropped, not deferred.
  always_comb begin
    tick_d  = edge_s & ~i_Freeze;
    speed_d = i_Speed;
  end

  // Tick pipeline registers
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      tick_q  <= 1'b0;
      speed_q <= 2'd0;
    end else begin
      tick_q  <= tick_d;
      speed_q <= speed_d;
    end
  end

  assign tick_act_s = tick_q & ~i_Freeze;
  assign pos_ext_s  = ARITH_W'(pos_q);
  assign step_s     = speed_to_step(speed_q);
  assign sum_down_s = pos_ext_s + step_s;
  assign sum_up_s   = pos_ext_s - step_s;

  // State, position and counter registers
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q       <= ST_WAIT_PHASE;
      pos_q         <= 9'sd0;
      phase_cnt_q   <= PHASE_INIT;
      pause_cnt_q   <= 16'd0;
      moving_down_q <= 1'b1;
      at_limit_q    <= 1'b0;
      updated_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      phase_cnt_q   <= phase_cnt_d;
      pause_cnt_q   <= pause_cnt_d;
      moving_down_q <= moving_down_d;
      at_limit_q    <= at_limit_d;
      updated_q     <= updated_d;
    end
  end

  // Next-state: at most one transition per accepted tick
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    phase_cnt_d = phase_cnt_q;
    pause_cnt_d = pause_cnt_q;
    if (tick_act_s) begin
      case (state_q)
        ST_WAIT_PHASE: begin
          if (phase_cnt_q == 16'd0) begin
            state_d = ST_MOVE_DOWN;
          end else begin
            phase_cnt_d = phase_cnt_q - 16'd1;
          end
        end
        ST_MOVE_DOWN: begin
          if (sum_down_s >= AMP_POS) begin
            pos_d       = POS_W'(AMP_POS);
            pause_cnt_d = PAUSE_INIT;
            state_d     = ST_PAUSE_BOTTOM;
          end else begin
            pos_d = POS_W'(sum_down_s);
          end
        end
        ST_PAUSE_BOTTOM: begin
          if (pause_cnt_q == 16'd0) begin
            state_d = ST_MOVE_UP;
          end else begin
            pause_cnt_d = pause_cnt_q - 16'd1;
          end
        end
        ST_MOVE_UP: begin
          if (sum_up_s <= AMP_NEG) begin
            pos_d       = POS_W'(AMP_NEG);
            pause_cnt_d = PAUSE_INIT;
            state_d     = ST_PAUSE_TOP;
          end else begin
            pos_d = POS_W'(sum_up_s);
          end
        end
        ST_PAUSE_TOP: begin
          if (pause_cnt_q == 16'd0) begin
            state_d = ST_MOVE_DOWN;
          end else begin
            pause_cnt_d = pause_cnt_q - 16'd1;
          end
        end
        default: begin
          state_d = ST_WAIT_PHASE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output decode from the upcoming state so flags register alongside position
  always_comb begin
    moving_down_d = 1'b0;
    at_limit_d    = 1'b0;
    updated_d     = (pos_d != pos_q);
    case (state_d)
      ST_WAIT_PHASE:   moving_down_d = 1'b1;
      ST_MOVE_DOWN:    moving_down_d = 1'b1;
      ST_PAUSE_BOTTOM: begin
        moving_down_d = 1'b1;
        at_limit_d    = 1'b1;
      end
      ST_MOVE_UP:      moving_down_d = 1'b0;
      ST_PAUSE_TOP:    at_limit_d    = 1'b1;
      default: begin
        moving_down_d = 1'b1;
        at_limit_d    = 1'b0;
      end
    endcase
  end

  assign o_Position   = pos_q;
  assign o_MovingDown = moving_down_q;
  assign o_AtLimit    = at_limit_q;
  assign o_Updated    = updated_q;

endmodule

// File: tb/tb_bar_motion_controller.sv
// Self-checking bench for bar_motion_controller: vector table, directed
// corner sequences and randomized ticks against a direction-based model.
module tb_bar_motion_controller;

  localparam int AMP   = 120;
  localparam int PAUSE = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              tick;
  logic              freeze;
  logic [1:0]        speed;
  logic signed [8:0] pos;
  logic signed [8:0] pos_ph;
  logic              down, lim, upd;
  logic              down_ph, lim_ph, upd_ph;

  always #5 clk = ~clk;

  bar_motion_controller dut (
    .i_Clk(clk), .i_Reset(rst), .i_NewFrameTick(tick), .i_Speed(speed),
    .i_Freeze(freeze), .o_Position(pos), .o_MovingDown(down),
    .o_AtLimit(lim), .o_Updated(upd)
  );

  bar_motion_controller #(.PHASE_DELAY_FRAMES(15)) dut_ph (
    .i_Clk(clk), .i_Reset(rst), .i_NewFrameTick(tick), .i_Speed(speed),
    .i_Freeze(freeze), .o_Position(pos_ph), .o_MovingDown(down_ph),
    .o_AtLimit(lim_ph), .o_Updated(upd_ph)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input int got, input int exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Reference model: position plus travel direction, phase and pause budgets.
  int m_pos, m_phase, m_pause, m_dir;
  bit m_wait, m_pausing;

  function automatic void model_reset();
    m_pos = 0; m_phase = 0; m_pause = 0; m_dir = 1;
    m_wait = 1'b1; m_pausing = 1'b0;
  endfunction

  function automatic void model_tick(input int spd);
    int nxt;
    if (m_wait) begin
      if (m_phase == 0) m_wait = 1'b0;
      else m_phase--;
    end else if (m_pausing) begin
      if (m_pause == 0) begin
        m_pausing = 1'b0;
        m_dir = -m_dir;
      end else m_pause--;
    end else begin
      nxt = m_pos + m_dir * (1 << spd);
      if ((m_dir > 0 && nxt >= AMP) || (m_dir < 0 && nxt <= -AMP)) begin
        m_pos = m_dir * AMP;
        m_pausing = 1'b1;
        m_pause = PAUSE;
      end else m_pos = nxt;
    end
  endfunction

  int obs_pos, obs_down, obs_lim, obs_upd, obs_upd2, obs_pph;

  task automatic do_reset(input bit tick_level);
    @(negedge clk); rst = 1'b1; tick = tick_level; freeze = 1'b0;
    @(negedge clk); rst = 1'b0;
    model_reset();
  endtask

  // One tick of 1..3 cycles; outputs observed in cycle T+2 and T+3.
  task automatic run_tick(input logic [1:0] spd, input int width);
    @(negedge clk); tick = 1'b1; speed = spd;
    @(negedge clk); if (width <= 1) tick = 1'b0;
    @(negedge clk); if (width == 2) tick = 1'b0;
    obs_pos = int'(pos); obs_down = int'(down); obs_lim = int'(lim);
    obs_upd = int'(upd); obs_pph = int'(pos_ph);
    @(negedge clk); if (width >= 3) tick = 1'b0;
    obs_upd2 = int'(upd);
    @(negedge clk);
  endtask

  task automatic model_check(input logic [1:0] spd, input int width, input string tag);
    int old;
    old = m_pos;
    run_tick(spd, width);
    if (!freeze) model_tick(int'(spd));
    chk({tag, "_pos"}, obs_pos, m_pos);
    chk({tag, "_down"}, obs_down, int'(m_wait || m_dir > 0));
    chk({tag, "_limit"}, obs_lim, int'(m_pausing));
    chk({tag, "_upd"}, obs_upd, int'(m_pos != old));
    chk({tag, "_upd_width"}, obs_upd2, 0);
  endtask

  typedef struct {
    logic [1:0] spd;
    bit         frz;
    int         pos;
    int         down;
    int         lim;
    int         upd;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{2'd0, 1'b0, 0,  1, 0, 0};
    vecs[1] = '{2'd0, 1'b0, 1,  1, 0, 1};
    vecs[2] = '{2'd1, 1'b0, 3,  1, 0, 1};
    vecs[3] = '{2'd2, 1'b0, 7,  1, 0, 1};
    vecs[4] = '{2'd3, 1'b0, 15, 1, 0, 1};
    vecs[5] = '{2'd3, 1'b1, 15, 1, 0, 0};
    vecs[6] = '{2'd0, 1'b0, 16, 1, 0, 1};
    vecs[7] = '{2'd3, 1'b1, 16, 1, 0, 0};
    vecs[8] = '{2'd2, 1'b0, 20, 1, 0, 1};

    rst = 1'b1; tick = 1'b0; freeze = 1'b0; speed = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();

    chk("reset_pos", int'(pos), 0);
    chk("reset_down", int'(down), 1);
    chk("reset_limit", int'(lim), 0);
    chk("reset_upd", int'(upd), 0);

    // Vector table
    for (int i = 0; i < 9; i++) begin
      freeze = vecs[i].frz;
      run_tick(vecs[i].spd, 1);
      freeze = 1'b0;
      chk($sformatf("vec%0d_pos", i), obs_pos, vecs[i].pos);
      chk($sformatf("vec%0d_down", i), obs_down, vecs[i].down);
      chk($sformatf("vec%0d_limit", i), obs_lim, vecs[i].lim);
      chk($sformatf("vec%0d_upd", i), obs_upd, vecs[i].upd);
    end

    // Full speed-0 sweep to the bottom limit; phase-delayed instance alongside
    do_reset(1'b0);
    for (int k = 1; k <= 121; k++) begin
      model_check(2'd0, 1, "sweep");
      chk("sweep_abs_pos", obs_pos, (k == 1) ? 0 : k - 1);
      chk("phase15_pos", obs_pph, (k <= 16) ? 0 : k - 16);
    end
    chk("sweep_at_limit", obs_lim, 1);

    // Speed 3 to the bottom, pause, and back up
    do_reset(1'b0);
    for (int k = 1; k <= 26; k++) begin
      model_check(2'd3, 1, "fast");
      if (k == 15) chk("fast_pos15", obs_pos, 112);
      if (k == 16) begin
        chk("fast_clamp", obs_pos, 120);
        chk("fast_clamp_limit", obs_lim, 1);
      end
      if (k == 25) begin
        chk("fast_move_up_down", obs_down, 0);
        chk("fast_move_up_limit", obs_lim, 0);
      end
      if (k == 26) chk("fast_first_up", obs_pos, 112);
    end
    for (int k = 0; k < 19; k++) model_check(2'd3, 1, "up");
    chk("up_pos_m40", obs_pos, -40);

    // Freeze held across three ticks mid-ascent
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      model_check(2'd3, 1, "frozen");
      chk("frozen_pos", obs_pos, -40);
    end
    freeze = 1'b0;
    model_check(2'd0, 1, "thaw");
    chk("thaw_pos", obs_pos, -41);

    for (int k = 0; k < 10; k++) model_check(2'd3, 1, "to_top");
    chk("top_clamp", obs_pos, -120);
    chk("top_limit", obs_lim, 1);
    chk("top_down", obs_down, 0);

    // Reset during PAUSE_TOP with a coincident tick
    @(negedge clk); rst = 1'b1; tick = 1'b1;
    @(negedge clk); rst = 1'b0; tick = 1'b0;
    model_reset();
    chk("rst_pause_pos", int'(pos), 0);
    chk("rst_pause_down", int'(down), 1);
    chk("rst_pause_limit", int'(lim), 0);
    chk("rst_pause_upd", int'(upd), 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_inflight_upd", int'(upd), 0);
      chk("rst_no_inflight_pos", int'(pos), 0);
    end
    model_check(2'd0, 1, "after_rst");
    model_check(2'd0, 1, "after_rst");
    chk("after_rst_pos1", obs_pos, 1);

    // Strobe already high when reset releases must not count
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    tick = 1'b0;
    repeat (2) @(negedge clk);
    model_check(2'd0, 1, "held_high");
    chk("held_high_pos", obs_pos, 0);
    model_check(2'd0, 1, "held_high");
    chk("held_high_pos1", obs_pos, 1);

    // Long strobe then short strobe: exactly two steps, pulse at T+2 each
    @(negedge clk); tick = 1'b1; speed = 2'd1;
    @(negedge clk);
    @(negedge clk);
    chk("long_upd", int'(upd), 1);
    chk("long_pos", int'(pos), 3);
    @(negedge clk);
    chk("long_upd_drop", int'(upd), 0);
    @(negedge clk);
    chk("long_no_repeat", int'(upd), 0);
    @(negedge clk); tick = 1'b0;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    chk("short_upd_early", int'(upd), 0);
    @(negedge clk);
    chk("short_upd", int'(upd), 1);
    chk("short_pos", int'(pos), 5);
    @(negedge clk);
    chk("short_upd_drop", int'(upd), 0);
    chk("short_pos_stable", int'(pos), 5);
    model_tick(1);
    model_tick(1);

    // Randomized ticks against the model
    do_reset(1'b0);
    for (int n = 0; n < 400; n++) begin
      freeze = ($urandom_range(0, 9) == 0);
      model_check(2'($urandom_range(0, 3)), $urandom_range(1, 3), "rand");
      freeze = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bar_motion_controller.md
BAR_MOTION_CONTROLLER -- requirements
Module: bar_motion_controller

Interface
REQ-001 SHALL have parameter PHASE_DELAY_FRAMES, default 0: frames waited after reset before motion starts.
REQ-002 SHALL have parameter AMPLITUDE, default 120: max |o_Position|; legal range 1..247.
REQ-003 SHALL have parameter PAUSE_FRAMES, default 8: extra ticks held at each limit.
REQ-004 SHALL have port i_Clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port i_Reset, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port i_NewFrameTick, input, 1: frame-start strobe from the VGA timing stage, same clock domain.
REQ-007 SHALL have port i_Speed, input, 2: step code; 0->1, 1->2, 2->4, 3->8 lines per tick.
REQ-008 SHALL have port i_Freeze, input, 1: when high, motion and all counters hold.
REQ-009 SHALL have port o_Position, output, signed 9: bar split-line offset from screen midpoint; positive = down.
REQ-010 SHALL have port o_MovingDown, output, 1: high in WAIT_PHASE, MOVE_DOWN and PAUSE_BOTTOM.
REQ-011 SHALL have port o_AtLimit, output, 1: high in PAUSE_BOTTOM and PAUSE_TOP.
REQ-012 SHALL have port o_Updated, output, 1: one-cycle pulse on the cycle o_Position changes value.

Function
REQ-013 SHALL detect ticks on rising edges of i_NewFrameTick only; a high level lasting N cycles counts as one tick.
REQ-014 SHALL ignore a tick edge whose cycle has i_Freeze high; that edge is not replayed later.
REQ-015 SHALL implement states WAIT_PHASE, MOVE_DOWN, PAUSE_BOTTOM, MOVE_UP, PAUSE_TOP; one transition at most per tick.
REQ-016 WAIT_PHASE, tick: counter==0 -> MOVE_DOWN, position unchanged; else counter decrements.
REQ-017 MOVE_DOWN, tick: next = position + step; if next >= AMPLITUDE, position = AMPLITUDE, pause counter = PAUSE_FRAMES, -> PAUSE_BOTTOM; else position = next.
REQ-018 MOVE_UP, tick: next = position - step; if next <= -AMPLITUDE, position = -AMPLITUDE, pause counter = PAUSE_FRAMES, -> PAUSE_TOP; else position = next.
REQ-019 PAUSE_BOTTOM/PAUSE_TOP, tick: counter==0 -> MOVE_UP/MOVE_DOWN respectively; else counter decrements; position held.
REQ-020 SHALL take step from i_Speed sampled on the tick cycle itself; no speed latch between ticks.
REQ-021 SHALL compute next position in 10-bit signed arithmetic; clamping prevents wrap; o_Position never exceeds ±AMPLITUDE.
REQ-022 Latency: tick edge detected in cycle T; o_Position, state and flags update at end of cycle T+1; o_Updated high during cycle T+2 only.
REQ-023 o_Updated SHALL NOT pulse on ticks that leave position unchanged (WAIT_PHASE, pauses, or a clamp equal to current value).
REQ-024 Between ticks all outputs except o_Updated SHALL be stable.

Reset
REQ-025 i_Reset high at a clock edge SHALL set: state WAIT_PHASE, phase counter PHASE_DELAY_FRAMES, pause counter 0, o_Position 0, o_MovingDown 1, o_AtLimit 0, o_Updated 0, edge-detect history 0.
REQ-026 Reset mid-motion SHALL discard any tick in flight; a tick coinciding with reset is ignored.
REQ-027 An i_NewFrameTick already high when reset releases SHALL NOT count as a tick.

Structure
REQ-028 Shared package SHALL hold: state encoding, speed-code-to-step table, position width (9), internal arithmetic width (10).
REQ-029 The rising-edge detector SHALL be a separate sub-module frame_tick_edge (inputs clock, reset, level; output one-cycle pulse).
REQ-030 Three instances with PHASE_DELAY_FRAMES 0/15/30 SHALL drive the three bars of the VGA colour stage.

Verification
REQ-031 Defaults, i_Speed=0, ticks 1..121 -> tick1 enters MOVE_DOWN pos 0; tick k (k≥2) pos = k-1; tick 121 pos 120, o_AtLimit=1.
REQ-032 Defaults, i_Speed=3 from reset -> positions 8,16,...,112 then clamp 120 on 16th tick; 9 ticks later state MOVE_UP; next tick pos 112.
REQ-033 PHASE_DELAY_FRAMES=15 -> position stays 0 for 16 ticks, first move to 1 on tick 17 (speed 0).
REQ-034 Tick held high 5 cycles, then low, then high 1 cycle -> exactly two steps; o_Updated pulses twice, each at T+2.
REQ-035 i_Freeze high across 3 ticks mid-MOVE_UP at pos -40 -> pos stays -40, counters unchanged; release, next tick pos -41.
REQ-036 Assert i_Reset during PAUSE_TOP with a coincident tick -> next cycle pos 0, WAIT_PHASE, o_Updated 0; following tick enters MOVE_DOWN.
